// File: rtl/debug_unit_pkg.sv
// debug_unit_pkg: shared types and constants for the CPU debug unit.
// Holds the FSM state encoding, response length and default start command.
package debug_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int N_RESP_BYTES = 6;
    localparam logic [7:0] START_CMD_DEF = 8'h53;

endpackage

// File: rtl/debug_unit_sat_counter.sv
// sat_counter: cycle counter that clears, counts when enabled, sticks at all-ones.
// Ports: clk, rst_n (async, active-low), clear, enable, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/debug_unit.sv
// debug_unit: UART-driven run control for a small CPU. A START_CMD byte starts
// a run; on HLT it reports PC, ACC and the enabled-cycle count as six bytes.
// Ports: CLK, RESET (async active-low), rx_empty/r_data/rd_uart (receive FIFO),
// tx_full/wr_uart/w_data (transmit FIFO), halt/pc/acc/cpu_en (CPU), busy.
// Build option: DEBUG_UNIT_ECHO_EN echoes non-start bytes back to the host.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int N_BIT   = 8,
    parameter int PC_BIT  = 11,
    parameter int ACC_BIT = 16,
    parameter int CNT_BIT = 16,
    parameter logic [N_BIT-1:0] START_CMD = N_BIT'(START_CMD_DEF)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               rx_empty,
    input  logic [N_BIT-1:0]   r_data,
    output logic               rd_uart,
    input  logic               tx_full,
    output logic               wr_uart,
    output logic [N_BIT-1:0]   w_data,
    input  logic               halt,
    input  logic [PC_BIT-1:0]  pc,
    input  logic [ACC_BIT-1:0] acc,
    output logic               cpu_en,
    output logic               busy
);

    localparam int W2    = 2 * N_BIT;
    localparam int IDX_W = $clog2(N_RESP_BYTES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_RESP_BYTES - 1);

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx;
    logic [PC_BIT-1:0]    pc_q;
    logic [ACC_BIT-1:0]   acc_q;
    logic [CNT_BIT-1:0]   count;
    logic                 clear;
    logic                 rd, wr;
    logic [N_BIT-1:0]     wd;
    logic [N_BIT-1:0]     resp_byte;
    logic [W2-1:0]        pc_ext, acc_ext, cnt_ext;

    // Counter stops once cpu_en drops, so in SEND it still holds the
    // value reached at the end of the halt cycle.
    sat_counter #(
        .W(CNT_BIT)
    ) u_cnt (
        .clk   (CLK),
        .rst_n (RESET),
        .clear (clear),
        .enable(cpu_en),
        .count (count)
    );

    assign cpu_en = (state == RUN);
    assign busy   = (state != IDLE);

    assign pc_ext  = W2'(pc_q);
    assign acc_ext = W2'(acc_q);
    assign cnt_ext = W2'(count);

    always_comb begin
        resp_byte = '0;
        case (idx)
            3'd0:    resp_byte = pc_ext[N_BIT-1:0];
            3'd1:    resp_byte = pc_ext[W2-1:N_BIT];
            3'd2:    resp_byte = acc_ext[N_BIT-1:0];
            3'd3:    resp_byte = acc_ext[W2-1:N_BIT];
            3'd4:    resp_byte = cnt_ext[N_BIT-1:0];
            3'd5:    resp_byte = cnt_ext[W2-1:N_BIT];
            default: resp_byte = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        rd      = 1'b0;
        wr      = 1'b0;
        wd      = '0;
        clear   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rx_empty) begin
                    if (r_data == START_CMD) begin
                        rd      = 1'b1;
                        clear   = 1'b1;
                        state_n = RUN;
                    end else begin
`ifdef DEBUG_UNIT_ECHO_EN
                        if (!tx_full) begin
                            rd = 1'b1;
                            wr = 1'b1;
                            wd = r_data;
                        end
`else
                        rd = 1'b1;
`endif
                    end
                end
            end
            RUN: begin
                if (halt) state_n = SEND;
            end
            SEND: begin
                wd = resp_byte;
                if (!tx_full) begin
                    wr = 1'b1;
                    if (idx == LAST) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FIFO strobes and data are forced low while reset is held, even
    // though they are otherwise combinational from the FIFO flags.
    assign rd_uart = rd & RESET;
    assign wr_uart = wr & RESET;
    assign w_data  = RESET ? wd : '0;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            idx <= '0;
        end else if (state != SEND) begin
            idx <= '0;
        end else if (wr) begin
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q  <= '0;
            acc_q <= '0;
        end else if ((state == RUN) && halt) begin
            pc_q  <= pc;
            acc_q <= acc;
        end
    end

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: self-checking bench for debug_unit with a receive-FIFO model
// and a transmit scoreboard; vector table plus hand-written corner sequences.
module tb_debug_unit;

    logic        CLK      = 1'b0;
    logic        RESET    = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data   = 8'h00;
    logic        rd_uart;
    logic        tx_full  = 1'b0;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        halt     = 1'b0;
    logic [10:0] pc       = '0;
    logic [15:0] acc      = '0;
    logic        cpu_en;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rxq[$];
    logic [7:0] exp_q[$];
    bit rd_seen  = 1'b0;
    int sent_cnt = 0;
    int en_cnt   = 0;
    int both_cnt = 0;

    typedef struct {
        logic [10:0] pc;
        logic [15:0] acc;
        int          n;
        int          stall_at;
        int          stall_len;
    } vec_t;

    debug_unit dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .rx_empty(rx_empty),
        .r_data  (r_data),
        .rd_uart (rd_uart),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .halt    (halt),
        .pc      (pc),
        .acc     (acc),
        .cpu_en  (cpu_en),
        .busy    (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Output monitor, mid-cycle.
    always @(negedge CLK) begin
        rd_seen = rd_uart;
        if (cpu_en) en_cnt++;
        if (rd_uart && wr_uart) both_cnt++;
        if (wr_uart) begin
            sent_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL tx_unexpected: got byte %0h expected none", w_data);
            end else begin
                chk("tx_byte", {24'h0, w_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Receive FIFO model: pop on rd_uart, registered flags.
    always @(posedge CLK) begin
        if (rd_seen) void'(rxq.pop_front());
        rx_empty <= (rxq.size() == 0);
        r_data   <= (rxq.size() != 0) ? rxq[0] : 8'h00;
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_resp(input logic [10:0] p, input logic [15:0] a,
                               input int n);
        logic [15:0] c;
        c = (n > 65535) ? 16'hFFFF : 16'(n);
        exp_q.push_back(p[7:0]);
        exp_q.push_back({5'b0, p[10:8]});
        exp_q.push_back(a[7:0]);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(c[15:8]);
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_en) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            step();
        end
        chk("send_done", {31'h0, done}, 32'h1);
    endtask

    task automatic do_run(input logic [10:0] p, input logic [15:0] a,
                          input int n, input int stall_at,
                          input int stall_len);
        bit ok;
        int e0, s0;
        rxq.push_back(8'h53);
        wait_run(ok);
        chk("run_start", {31'h0, ok}, 32'h1);
        if (!ok) return;
        e0 = en_cnt;
        s0 = sent_cnt;
        for (int k = 1; k < n; k++) step();
        halt = 1'b1;
        pc   = p;
        acc  = a;
        expect_resp(p, a, n);
        step();
        halt = 1'b0;
        chk("cpu_en_off", {31'h0, cpu_en}, 32'h0);
        chk("busy_send", {31'h0, busy}, 32'h1);
        if (stall_at >= 0) begin
            for (int i = 0; i < 50 && (sent_cnt - s0) < stall_at; i++) step();
            tx_full = 1'b1;
            for (int i = 0; i < stall_len; i++) begin
                @(negedge CLK);
                chk("stall_wr", {31'h0, wr_uart}, 32'h0);
            end
            chk("stall_idx", sent_cnt - s0, stall_at);
            @(posedge CLK);
            #1;
            tx_full = 1'b0;
        end
        wait_idle();
        chk("bytes_sent", sent_cnt - s0, 6);
        chk("en_cycles", en_cnt - e0, n);
    endtask

    vec_t vecs[4];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int s0, e0;

        vecs[0] = '{pc: 11'h005, acc: 16'h1234, n: 10,  stall_at: -1, stall_len: 0};
        vecs[1] = '{pc: 11'h7FF, acc: 16'hFFFF, n: 3,   stall_at: 2,  stall_len: 5};
        vecs[2] = '{pc: 11'h400, acc: 16'h00AB, n: 1,   stall_at: -1, stall_len: 0};
        vecs[3] = '{pc: 11'h123, acc: 16'h8001, n: 300, stall_at: 5,  stall_len: 2};

        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy",   {31'h0, busy},    32'h0);
        chk("rst_cpu_en", {31'h0, cpu_en},  32'h0);
        chk("rst_rd",     {31'h0, rd_uart}, 32'h0);
        chk("rst_wr",     {31'h0, wr_uart}, 32'h0);
        chk("rst_wdata",  {24'h0, w_data},  32'h0);
        RESET = 1'b1;
        step();

        foreach (vecs[i])
            do_run(vecs[i].pc, vecs[i].acc, vecs[i].n,
                   vecs[i].stall_at, vecs[i].stall_len);

        // Non-start byte.
        s0 = sent_cnt;
        e0 = en_cnt;
`ifdef DEBUG_UNIT_ECHO_EN
        exp_q.push_back(8'h41);
`endif
        rxq.push_back(8'h41);
        repeat (5) step();
        chk("mm_popped", rxq.size(), 0);
        chk("mm_no_run", en_cnt - e0, 0);
`ifdef DEBUG_UNIT_ECHO_EN
        chk("mm_echo", sent_cnt - s0, 1);
        tx_full = 1'b1;
        exp_q.push_back(8'h42);
        rxq.push_back(8'h42);
        repeat (4) step();
        chk("echo_held", rxq.size(), 1);
        tx_full = 1'b0;
        repeat (3) step();
        chk("echo_popped", rxq.size(), 0);
`else
        chk("mm_no_wr", sent_cnt - s0, 0);
`endif

        // Halt held high before the start command.
        halt = 1'b1;
        repeat (3) step();
        chk("halt_idle_ignored", {31'h0, busy}, 32'h0);
        do_run(11'h0C3, 16'hBEEF, 1, -1, 0);

        // Reset in the middle of SEND, with a byte queued during RUN.
        rxq.push_back(8'h53);
        wait_run(ok);
        chk("rst_run_start", {31'h0, ok}, 32'h1);
        rxq.push_back(8'h41);
        repeat (3) step();
        halt = 1'b1;
        pc   = 11'h2F0;
        acc  = 16'hCAFE;
        expect_resp(11'h2F0, 16'hCAFE, 4);
        step();
        halt = 1'b0;
        chk("rx_held_in_run", rxq.size(), 1);
        s0 = sent_cnt;
        for (int i = 0; i < 50 && (sent_cnt - s0) < 3; i++) step();
        chk("pre_rst_sent", sent_cnt - s0, 3);
        RESET = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy},    32'h0);
        chk("midrst_wr",   {31'h0, wr_uart}, 32'h0);
        chk("midrst_en",   {31'h0, cpu_en},  32'h0);
        exp_q.delete();
        repeat (2) step();
        RESET = 1'b1;
`ifdef DEBUG_UNIT_ECHO_EN
        exp_q.push_back(8'h41);
`endif
        repeat (4) step();
        chk("queued_drained", rxq.size(), 0);
        do_run(11'h011, 16'h0F0F, 6, -1, 0);

        // Counter saturation.
        do_run(11'h2AA, 16'h5555, 70000, -1, 0);

`ifndef DEBUG_UNIT_ECHO_EN
        chk("rd_wr_exclusive", both_cnt, 0);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
